move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 new_game  input  1  single-cycle pulse that clears the board and restarts play.
REQ-005 p1_play  input  1  single-cycle move strobe from player 1 (X).
REQ-006 p1_pos  input  4  player 1 target square; 1..9 legal, 0 and 10..15 invalid.
REQ-007 p2_play  input  1  single-cycle move strobe from player 2 (O).
REQ-008 p2_pos  input  4  player 2 target square, same encoding as p1_pos.
REQ-009 winner  input  1  win flag from the downstream win detector, combinational on pos1..pos9.
REQ-010 who  input  2  winning player code from the downstream win detector.
REQ-011 pos1..pos9  output  2 each  square contents: 00 empty, 01 player 1, 10 player 2; 11 is never driven.
REQ-012 turn  output  1  0 = player 1 to move, 1 = player 2 to move.
REQ-013 illegal_move  output  1  one-cycle pulse when a move is rejected.
REQ-014 game_over  output  1  high while in DONE.
REQ-015 draw  output  1  high in DONE when the board is full and there is no winner.
REQ-016 result  output  2  latched who on a win; 00 on a draw or while play continues.
REQ-017 move_count  output  4  count of accepted moves, 0..9.

Function
REQ-018 The FSM SHALL have four states: P1_TURN, P2_TURN, CHECK, DONE.
REQ-019 In P1_TURN the block SHALL sample only p1_play/p1_pos, and in P2_TURN only p2_play/p2_pos; the strobe of the non-current player SHALL be ignored without an error pulse, including when both strobes are high in the same cycle.
REQ-020 A move is accepted when the square number is 1..9 and the target square is 00; on the next edge the square SHALL be written with the mover's code, move_count SHALL increment, and the state SHALL go to CHECK.
REQ-021 A move to an invalid or occupied square SHALL leave the board, move_count and state unchanged, and SHALL assert illegal_move for exactly the following cycle.
REQ-022 In CHECK, which lasts exactly one cycle, the block SHALL evaluate winner/who against the updated board and ignore all move strobes.
REQ-023 From CHECK, the next state SHALL be chosen in this order: if winner=1, go to DONE and latch result=who; else if all nine squares are non-zero, go to DONE and set draw=1; else go to the other player's turn state.
REQ-024 turn SHALL reflect the player whose move is awaited; in CHECK it SHALL hold the value of the player who just moved, and in DONE it SHALL hold that player's value.
REQ-025 Latency from an accepted strobe to the square updating SHALL be 1 cycle; latency to the next player's turn or to DONE SHALL be 2 cycles.
REQ-026 In DONE, the board, result, draw and move_count SHALL be frozen and all strobes ignored.
REQ-027 new_game SHALL clear the board, result, draw, game_over and move_count, and SHALL enter P1_TURN on the next edge from any state; new_game SHALL take priority over a move strobe in the same cycle.
REQ-028 move_count SHALL never exceed 9, and no tenth write SHALL be possible.

Reset
REQ-029 On reset, pos1..pos9 SHALL be 00, state P1_TURN, turn 0, illegal_move 0, game_over 0, draw 0, result 00, and move_count 0.
REQ-030 reset SHALL take priority over new_game and all strobes, and asserting it mid-game or in DONE SHALL abandon the game immediately.

Verification
REQ-031 After reset, apply p1_play with p1_pos=5 -> pos5=01 next cycle, move_count=1, CHECK, then turn=1.
REQ-032 In P2_TURN with pos5=01, apply p2_play with p2_pos=5 -> illegal_move high for 1 cycle, board unchanged, turn stays 1; then apply p2_pos=0 -> illegal_move again.
REQ-033 Play P1:1, P2:4, P1:2, P2:5, P1:3 with the detector in loop -> after the fifth move, game_over=1, result=01, draw=0, and later strobes are ignored.
REQ-034 Play a full 9-move no-win sequence (X at 1,3,4,8,9 and O at 2,5,6,7) -> move_count=9, draw=1, result=00, game_over=1.
REQ-035 Assert p1_play and p2_play together in P1_TURN -> only the P1 move is applied; assert new_game together with p1_play -> empty board, P1_TURN, no write.
REQ-036 Assert reset in the cycle an accepted move would be in CHECK -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/move_controller_if.sv
// Move/board bus between the tic-tac-toe move controller, its players and
// the external win detector.
interface move_controller_if;
  logic       new_game;
  logic       p1_play;
  logic [3:0] p1_pos;
  logic       p2_play;
  logic [3:0] p2_pos;
  logic       winner;
  logic [1:0] who;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       turn;
  logic       illegal_move;
  logic       game_over;
  logic       draw;
  logic [1:0] result;
  logic [3:0] move_count;

  modport master (
    output new_game, p1_play, p1_pos, p2_play, p2_pos, winner, who,
    input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    input  turn, illegal_move, game_over, draw, result, move_count
  );

  modport slave (
    input  new_game, p1_play, p1_pos, p2_play, p2_pos, winner, who,
    output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    output turn, illegal_move, game_over, draw, result, move_count
  );
endinterface

// File: rtl/move_controller.sv
// Tic-tac-toe move controller: validates alternating moves, owns the board,
// and resolves win/draw from the external detector one cycle after each move.
module move_controller (
  input  logic             clock,
  input  logic             reset,
  move_controller_if.slave bus
);
  typedef enum logic [1:0] {P1_TURN, P2_TURN, CHECK, DONE} state_t;

  state_t          state;
  logic [9:1][1:0] board;
  logic            turn_q, ill_q, over_q, draw_q;
  logic [1:0]      result_q;
  logic [3:0]      count_q;

  logic            cur_play, cur_ok, full;
  logic [3:0]      cur_pos;
  logic [1:0]      code;

  // Only the player whose move is awaited is ever sampled.
  always_comb begin
    cur_play = (state == P2_TURN) ? bus.p2_play : bus.p1_play;
    cur_pos  = (state == P2_TURN) ? bus.p2_pos  : bus.p1_pos;
    code     = turn_q ? 2'b10 : 2'b01;
    cur_ok   = 1'b0;
    full     = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (cur_pos == 4'(i) && board[i] == 2'b00) cur_ok = 1'b1;
      if (board[i] == 2'b00) full = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // reset and new_game clear the same state; reset simply wins the OR.
    if (reset || bus.new_game) begin
      state    <= P1_TURN;
      board    <= '0;
      turn_q   <= 1'b0;
      ill_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      result_q <= 2'b00;
      count_q  <= 4'd0;
    end else begin
      ill_q <= 1'b0;
      case (state)
        P1_TURN, P2_TURN: begin
          if (cur_play) begin
            if (cur_ok) begin
              for (int i = 1; i <= 9; i++)
                if (cur_pos == 4'(i)) board[i] <= code;
              count_q <= count_q + 4'd1;
              state   <= CHECK;
            end else begin
              ill_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (bus.winner) begin
            state    <= DONE;
            over_q   <= 1'b1;
            result_q <= bus.who;
          end else if (full) begin
            state  <= DONE;
            over_q <= 1'b1;
            draw_q <= 1'b1;
          end else begin
            state  <= turn_q ? P1_TURN : P2_TURN;
            turn_q <= ~turn_q;
          end
        end
        DONE:    ;
        default: state <= P1_TURN;
      endcase
    end
  end

  assign bus.pos1         = board[1];
  assign bus.pos2         = board[2];
  assign bus.pos3         = board[3];
  assign bus.pos4         = board[4];
  assign bus.pos5         = board[5];
  assign bus.pos6         = board[6];
  assign bus.pos7         = board[7];
  assign bus.pos8         = board[8];
  assign bus.pos9         = board[9];
  assign bus.turn         = turn_q;
  assign bus.illegal_move = ill_q;
  assign bus.game_over    = over_q;
  assign bus.draw         = draw_q;
  assign bus.result       = result_q;
  assign bus.move_count   = count_q;
endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed game scenarios plus random play, all
// checked every cycle against a move-level game model.
module tb_move_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  move_controller_if bus();

  move_controller dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  // Model of the game: board contents, moves made, whose move is awaited,
  // whether a just-made move still awaits adjudication, and the final outcome.
  int mb [1:9];
  int m_cnt, m_turn, m_pend, m_done, m_ill, m_draw, m_res;

  function automatic logic [1:0] line3(logic [1:0] a, logic [1:0] b, logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  function automatic logic [1:0] win9(logic [1:0] s1, s2, s3, s4, s5, s6, s7, s8, s9);
    logic [1:0] w [8];
    w[0] = line3(s1, s2, s3); w[1] = line3(s4, s5, s6); w[2] = line3(s7, s8, s9);
    w[3] = line3(s1, s4, s7); w[4] = line3(s2, s5, s8); w[5] = line3(s3, s6, s9);
    w[6] = line3(s1, s5, s9); w[7] = line3(s3, s5, s7);
    for (int i = 0; i < 8; i++) if (w[i] != 2'b00) return w[i];
    return 2'b00;
  endfunction

  // Downstream win detector, in loop with the DUT's board.
  always_comb begin
    bus.who    = win9(bus.pos1, bus.pos2, bus.pos3, bus.pos4, bus.pos5,
                      bus.pos6, bus.pos7, bus.pos8, bus.pos9);
    bus.winner = (bus.who != 2'b00);
  end

  function automatic int dut_pos(int i);
    case (i)
      1: return int'(bus.pos1); 2: return int'(bus.pos2); 3: return int'(bus.pos3);
      4: return int'(bus.pos4); 5: return int'(bus.pos5); 6: return int'(bus.pos6);
      7: return int'(bus.pos7); 8: return int'(bus.pos8); default: return int'(bus.pos9);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 1; i <= 9; i++) mb[i] = 0;
    m_cnt = 0; m_turn = 0; m_pend = 0; m_done = 0; m_ill = 0; m_draw = 0; m_res = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int play, pos;
    logic [1:0] w;
    if (reset || bus.new_game) begin
      model_clear();
      return;
    end
    m_ill = 0;
    if (m_done != 0) return;
    if (m_pend != 0) begin
      m_pend = 0;
      w = win9(2'(mb[1]), 2'(mb[2]), 2'(mb[3]), 2'(mb[4]), 2'(mb[5]),
               2'(mb[6]), 2'(mb[7]), 2'(mb[8]), 2'(mb[9]));
      if (w != 2'b00) begin m_done = 1; m_res = int'(w); end
      else if (m_cnt == 9) begin m_done = 1; m_draw = 1; end
      else m_turn = 1 - m_turn;
      return;
    end
    play = (m_turn == 0) ? int'(bus.p1_play) : int'(bus.p2_play);
    pos  = (m_turn == 0) ? int'(bus.p1_pos)  : int'(bus.p2_pos);
    if (play != 0) begin
      if (pos >= 1 && pos <= 9 && mb[pos] == 0) begin
        mb[pos] = m_turn + 1;
        m_cnt++;
        m_pend = 1;
      end else m_ill = 1;
    end
  endtask

  task automatic compare();
    for (int i = 1; i <= 9; i++) chk($sformatf("pos%0d", i), dut_pos(i), mb[i]);
    chk("turn", int'(bus.turn), m_turn);
    chk("illegal_move", int'(bus.illegal_move), m_ill);
    chk("game_over", int'(bus.game_over), m_done);
    chk("draw", int'(bus.draw), m_draw);
    chk("result", int'(bus.result), m_res);
    chk("move_count", int'(bus.move_count), m_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic idle();
    bus.new_game = 0; bus.p1_play = 0; bus.p2_play = 0;
    bus.p1_pos = 4'd0; bus.p2_pos = 4'd0; reset = 0;
  endtask

  // One strobe then one quiet cycle (the adjudication cycle).
  task automatic mv(int p, int pos);
    if (p == 1) begin bus.p1_play = 1; bus.p1_pos = 4'(pos); end
    else        begin bus.p2_play = 1; bus.p2_pos = 4'(pos); end
    tick();
    idle();
    tick();
  endtask

  task automatic new_game();
    bus.new_game = 1; tick(); idle();
  endtask

  initial begin
    idle();
    reset = 1;
    model_clear();
    tick(); tick();
    chk("reset move_count", int'(bus.move_count), 0);
    chk("reset turn", int'(bus.turn), 0);
    idle();

    // First move to centre, then illegal replies from player 2.
    bus.p1_play = 1; bus.p1_pos = 4'd5; tick(); idle();
    chk("lit pos5 after move", int'(bus.pos5), 1);
    chk("lit count after move", int'(bus.move_count), 1);
    chk("lit turn in check", int'(bus.turn), 0);
    tick();
    chk("lit turn after check", int'(bus.turn), 1);
    bus.p2_play = 1; bus.p2_pos = 4'd5; tick(); idle();
    chk("lit illegal occupied", int'(bus.illegal_move), 1);
    tick();
    chk("lit illegal one cycle", int'(bus.illegal_move), 0);
    bus.p2_play = 1; bus.p2_pos = 4'd0; tick(); idle();
    chk("lit illegal zero", int'(bus.illegal_move), 1);
    tick();

    // X wins on the top row; later strobes ignored.
    new_game();
    mv(1, 1); mv(2, 4); mv(1, 2); mv(2, 5); mv(1, 3);
    chk("lit win over", int'(bus.game_over), 1);
    chk("lit win result", int'(bus.result), 1);
    chk("lit win draw", int'(bus.draw), 0);
    mv(2, 9); mv(1, 9);
    chk("lit frozen pos9", int'(bus.pos9), 0);

    // Full-board draw.
    new_game();
    mv(1, 1); mv(2, 2); mv(1, 3); mv(2, 5); mv(1, 4);
    mv(2, 6); mv(1, 8); mv(2, 7); mv(1, 9);
    chk("lit draw count", int'(bus.move_count), 9);
    chk("lit draw flag", int'(bus.draw), 1);
    chk("lit draw result", int'(bus.result), 0);
    chk("lit draw over", int'(bus.game_over), 1);

    // Both strobes in P1's turn; new_game beating a strobe.
    new_game();
    bus.p1_play = 1; bus.p1_pos = 4'd1; bus.p2_play = 1; bus.p2_pos = 4'd2; tick(); idle();
    chk("lit both pos1", int'(bus.pos1), 1);
    chk("lit both pos2", int'(bus.pos2), 0);
    tick();
    bus.new_game = 1; bus.p2_play = 1; bus.p2_pos = 4'd3; tick(); idle();
    chk("lit ng pos3", int'(bus.pos3), 0);
    chk("lit ng turn", int'(bus.turn), 0);
    bus.new_game = 1; bus.p1_play = 1; bus.p1_pos = 4'd7; tick(); idle();
    chk("lit ng pos7", int'(bus.pos7), 0);

    // Reset landing in the adjudication cycle.
    bus.p1_play = 1; bus.p1_pos = 4'd5; tick(); idle();
    reset = 1; tick(); idle();
    chk("lit rst pos5", int'(bus.pos5), 0);
    chk("lit rst count", int'(bus.move_count), 0);
    bus.p1_play = 1; bus.p1_pos = 4'd2; tick(); idle();
    chk("lit rst then p1 move", int'(bus.pos2), 1);
    tick();

    // Random play, mostly legal-range squares, occasional new game/reset.
    for (int n = 0; n < 4000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      bus.new_game = ($urandom_range(0, 79) == 0);
      bus.p1_play  = 1'($urandom_range(0, 1));
      bus.p2_play  = 1'($urandom_range(0, 1));
      bus.p1_pos   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
      bus.p2_pos   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
